// File: rtl/cond_pkg.sv
// Shared types for the pipelined ARM condition logic: condition codes,
// the NZCV flag layout and FlagW bit positions.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // FlagW[1] writes N,Z; FlagW[0] writes C,V.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  // Control bits that travel to the M stage.
  typedef struct packed {
    logic pcs;
    logic mem;
  } m_stage_t;

endpackage

// File: rtl/cond_logic_pipe_cond_check.sv
// Purely combinational ARM condition-code evaluation against one NZCV set.
// Shared with the branch predictor, so it holds no state.
module cond_check
  import cond_pkg::*;
(
  input  cond_e  cond_i,
  input  flags_t flags_i,
  output logic   pass_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path can leave it unassigned and infer a latch.
    pass_o = 1'b0;
    case (cond_i)
      EQ: pass_o = flags_i.z;
      NE: pass_o = ~flags_i.z;
      CS: pass_o = flags_i.c;
      CC: pass_o = ~flags_i.c;
      MI: pass_o = flags_i.n;
      PL: pass_o = ~flags_i.n;
      VS: pass_o = flags_i.v;
      VC: pass_o = ~flags_i.v;
      HI: pass_o = flags_i.c & ~flags_i.z;
      LS: pass_o = ~flags_i.c | flags_i.z;
      GE: pass_o = (flags_i.n == flags_i.v);
      LT: pass_o = (flags_i.n != flags_i.v);
      GT: pass_o = ~flags_i.z & (flags_i.n == flags_i.v);
      LE: pass_o = flags_i.z | (flags_i.n != flags_i.v);
      AL: pass_o = 1'b1;
      NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic_pipe.sv
// Pipelined ARM conditional logic: banked NZCV flags, condition gating and
// stall/flush-aware delivery of PCSrc/MemWrite (M) and RegWrite (W).
// Optional macro COND_UNDEF_TRAP_EN adds the undef_trap output for Cond==NV.
module cond_logic_pipe
  import cond_pkg::*;
#(
  parameter int CTX_N  = 2,
  parameter int WB_LAT = 2,
  parameter int CW     = (CTX_N > 1) ? $clog2(CTX_N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic [CW-1:0] ctx_sel,
  input  logic [3:0]    Cond,
  input  logic [3:0]    ALUFlags,
  input  logic [1:0]    FlagW,
  input  logic          PCS,
  input  logic          RegW,
  input  logic          MemW,
  input  logic          NoWrite,
  input  logic          flags_load,
  input  logic [3:0]    flags_in,
  output logic          CondEx,
  output logic [3:0]    Flags,
  output logic          PCSrc,
  output logic          MemWrite,
  output logic          RegWrite
`ifdef COND_UNDEF_TRAP_EN
  ,
  output logic          undef_trap
`endif
);

  flags_t bank_q [CTX_N];
  flags_t bank_d [CTX_N];
  flags_t sel_flags;
  logic   ctx_hit;
  logic   cond_pass;

  // An out-of-range ctx_sel matches no bank: flags read as zero, nothing passes.
  always_comb begin
    sel_flags = '0;
    ctx_hit   = 1'b0;
    for (int i = 0; i < CTX_N; i++) begin
      if (ctx_sel == CW'(i)) begin
        sel_flags = bank_q[i];
        ctx_hit   = 1'b1;
      end
    end
  end

  cond_check u_cond_check (
    .cond_i  (cond_e'(Cond)),
    .flags_i (sel_flags),
    .pass_o  (cond_pass)
  );

  assign CondEx = ctx_hit & cond_pass;
  assign Flags  = sel_flags;

  logic pcs_g;
  logic mem_g;
  logic reg_g;

  assign pcs_g = PCS & CondEx;
  assign mem_g = MemW & CondEx;
  assign reg_g = RegW & CondEx & ~NoWrite;

  // An MSR-style load beats a same-cycle ALU update and ignores flush/Cond.
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < CTX_N; i++) begin
      if ((ctx_sel == CW'(i)) && !stall) begin
        if (flags_load) begin
          bank_d[i] = flags_t'(flags_in);
        end else if (!flush && CondEx) begin
          if (FlagW[FLAGW_NZ]) {bank_d[i].n, bank_d[i].z} = ALUFlags[3:2];
          if (FlagW[FLAGW_CV]) {bank_d[i].c, bank_d[i].v} = ALUFlags[1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the flag banks are architectural state visible on Flags, so
    // every entry is reset rather than left to power-up contents.
    if (reset) begin
      bank_q <= '{default: '0};
    end else begin
      bank_q <= bank_d;
    end
  end

  m_stage_t          m_q;
  m_stage_t          m_d;
  logic [WB_LAT-1:0] reg_line_q;
  logic [WB_LAT-1:0] reg_line_d;

  // Bit 0 of reg_line is the stage-1 copy; the last bit drives RegWrite.
  always_comb begin
    m_d        = m_q;
    reg_line_d = reg_line_q;
    if (!stall) begin
      if (flush) begin
        m_d = '0;
      end else begin
        m_d.pcs = pcs_g;
        m_d.mem = mem_g;
      end
      reg_line_d[0] = ~flush & reg_g;
      for (int i = 1; i < WB_LAT; i++) begin
        reg_line_d[i] = reg_line_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      m_q        <= '0;
      reg_line_q <= '0;
    end else begin
      m_q        <= m_d;
      reg_line_q <= reg_line_d;
    end
  end

  assign PCSrc    = m_q.pcs;
  assign MemWrite = m_q.mem;
  assign RegWrite = reg_line_q[WB_LAT-1];

`ifdef COND_UNDEF_TRAP_EN
  logic undef_q;
  logic undef_d;

  always_comb begin
    undef_d = undef_q;
    if (!stall) begin
      undef_d = ~flush & (cond_e'(Cond) == NV);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      undef_q <= 1'b0;
    end else begin
      undef_q <= undef_d;
    end
  end

  assign undef_trap = undef_q;
`endif

endmodule

// File: tb/tb_cond_logic_pipe.sv
// Self-checking bench for cond_logic_pipe: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the flag banks.
module tb_cond_logic_pipe;

  localparam int CTX_N  = 2;
  localparam int WB_LAT = 2;
  localparam int CW     = (CTX_N > 1) ? $clog2(CTX_N) : 1;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          flush;
  logic [CW-1:0] ctx_sel;
  logic [3:0]    Cond;
  logic [3:0]    ALUFlags;
  logic [1:0]    FlagW;
  logic          PCS;
  logic          RegW;
  logic          MemW;
  logic          NoWrite;
  logic          flags_load;
  logic [3:0]    flags_in;
  logic          CondEx;
  logic [3:0]    Flags;
  logic          PCSrc;
  logic          MemWrite;
  logic          RegWrite;
`ifdef COND_UNDEF_TRAP_EN
  logic          undef_trap;
`endif

  cond_logic_pipe #(
    .CTX_N  (CTX_N),
    .WB_LAT (WB_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .ctx_sel    (ctx_sel),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .flags_load (flags_load),
    .flags_in   (flags_in),
    .CondEx     (CondEx),
    .Flags      (Flags),
    .PCSrc      (PCSrc),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite)
`ifdef COND_UNDEF_TRAP_EN
    ,
    .undef_trap (undef_trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0] mflags [CTX_N];
  bit         m_pcs;
  bit         m_mem;
  bit         m_undef;
  bit         regq [$];

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_f(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ARM codes come in complementary pairs: odd codes invert the even base test.
  function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  function automatic bit sel_ok();
    return int'(ctx_sel) < CTX_N;
  endfunction

  function automatic logic [3:0] model_flags();
    return sel_ok() ? mflags[ctx_sel] : 4'h0;
  endfunction

  function automatic bit model_ce();
    return sel_ok() && ref_pass(Cond, model_flags());
  endfunction

  task automatic model_edge(input bit ce);
    if (reset) begin
      for (int i = 0; i < CTX_N; i++) mflags[i] = 4'h0;
      m_pcs = 0; m_mem = 0; m_undef = 0;
      regq.delete();
      repeat (WB_LAT) regq.push_back(1'b0);
    end else if (!stall) begin
      m_pcs   = !flush && PCS && ce;
      m_mem   = !flush && MemW && ce;
      m_undef = !flush && (Cond == 4'hF);
      regq.push_front(!flush && RegW && ce && !NoWrite);
      void'(regq.pop_back());
      if (sel_ok()) begin
        if (flags_load) mflags[ctx_sel] = flags_in;
        else if (!flush && ce) begin
          if (FlagW[1]) mflags[ctx_sel][3:2] = ALUFlags[3:2];
          if (FlagW[0]) mflags[ctx_sel][1:0] = ALUFlags[1:0];
        end
      end
    end
  endtask

  // One clock: check combinational outputs, clock the edge, check registered outputs.
  task automatic run_cycle();
    bit ce;
    #1;
    ce = model_ce();
    if (!reset) begin
      check_b("condex", CondEx, ce);
      check_f("flags", Flags, model_flags());
    end
    @(posedge clk);
    model_edge(ce);
    #1;
    check_b("pcsrc", PCSrc, m_pcs);
    check_b("memwrite", MemWrite, m_mem);
    check_b("regwrite", RegWrite, regq[WB_LAT-1]);
`ifdef COND_UNDEF_TRAP_EN
    check_b("undef_trap", undef_trap, m_undef);
`endif
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; flush = 0; ctx_sel = '0;
    Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    flags_load = 0; flags_in = 4'h0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    run_cycle();
    run_cycle();
    check_f("reset_flags", Flags, 4'h0);
    check_b("reset_pcsrc", PCSrc, 1'b0);
    check_b("reset_regwrite", RegWrite, 1'b0);

    // EQ fails with Z=0; AL arrives at RegWrite exactly two edges later
    clear_inputs(); Cond = 4'h0; RegW = 1;
    run_cycle();
    check_b("eq_condex", CondEx, 1'b0);
    clear_inputs(); Cond = 4'hE; RegW = 1;
    run_cycle();
    check_b("rw_lat1", RegWrite, 1'b0);
    clear_inputs();
    run_cycle();
    check_b("rw_lat2", RegWrite, 1'b1);

    // Partial flag write NZ only, then dependent EQ store
    clear_inputs(); Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b0100;
    run_cycle();
    check_f("flagw_nz", Flags, 4'b0100);
    clear_inputs(); Cond = 4'h0; MemW = 1;
    run_cycle();
    check_b("memw_eq", MemWrite, 1'b1);

    // Full decode sweep through flags_load
    for (int f = 0; f < 16; f++) begin
      clear_inputs(); flags_load = 1; flags_in = 4'(f);
      run_cycle();
      clear_inputs();
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        run_cycle();
      end
    end
    clear_inputs(); flags_load = 1; flags_in = 4'b1001;
    run_cycle();
    clear_inputs(); Cond = 4'hC;
    #1 check_b("gt_1001", CondEx, 1'b1);
    clear_inputs(); flags_load = 1; flags_in = 4'b1101;
    run_cycle();
    clear_inputs(); Cond = 4'hC;
    #1 check_b("gt_1101", CondEx, 1'b0);

    // Failed condition suppresses flag update; NoWrite kills RegWrite
    clear_inputs(); flags_load = 1; flags_in = 4'b0100;
    run_cycle();
    clear_inputs(); Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b0011;
    run_cycle();
    check_f("ne_supp", Flags, 4'b0100);
    clear_inputs(); Cond = 4'hE; RegW = 1; NoWrite = 1;
    run_cycle();
    clear_inputs();
    run_cycle();
    check_b("nowrite", RegWrite, 1'b0);

    // Flush kills the E instruction and its flag update
    clear_inputs(); PCS = 1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1111; flush = 1;
    run_cycle();
    check_b("flush_pcs", PCSrc, 1'b0);
    check_f("flush_flags", Flags, 4'b0100);

    // Stall holds outputs; stall beats flush
    clear_inputs(); PCS = 1; Cond = 4'hE;
    run_cycle();
    check_b("pcs_taken", PCSrc, 1'b1);
    clear_inputs(); stall = 1; flags_load = 1; flags_in = 4'b1111;
    repeat (3) begin
      run_cycle();
      check_b("stall_hold", PCSrc, 1'b1);
    end
    check_f("stall_flags", Flags, 4'b0100);
    clear_inputs(); stall = 1; flush = 1;
    run_cycle();
    check_b("stall_flush", PCSrc, 1'b1);
    clear_inputs();
    run_cycle();
    check_b("after_stall", PCSrc, 1'b0);

    // Banked contexts
    clear_inputs(); flags_load = 1; flags_in = 4'b0000;
    run_cycle();
    clear_inputs(); ctx_sel = 1; flags_load = 1; flags_in = 4'b1000;
    run_cycle();
    clear_inputs();
    #1 check_f("bank0_kept", Flags, 4'b0000);
    ctx_sel = 1; Cond = 4'h4;
    #1 check_b("mi_ctx1", CondEx, 1'b1);
    ctx_sel = 0;
    #1 check_b("mi_ctx0", CondEx, 1'b0);

`ifdef COND_UNDEF_TRAP_EN
    clear_inputs(); Cond = 4'hF;
    run_cycle();
    check_b("undef_set", undef_trap, 1'b1);
    clear_inputs(); Cond = 4'hF; flush = 1;
    run_cycle();
    check_b("undef_flush", undef_trap, 1'b0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 99) == 0);
      stall      = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      ctx_sel    = CW'($urandom_range(0, (1 << CW) - 1));
      Cond       = 4'($urandom);
      ALUFlags   = 4'($urandom);
      FlagW      = 2'($urandom);
      PCS        = 1'($urandom);
      RegW       = 1'($urandom);
      MemW       = 1'($urandom);
      NoWrite    = ($urandom_range(0, 3) == 0);
      flags_load = ($urandom_range(0, 7) == 0);
      flags_in   = 4'($urandom);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_logic_pipe.md
Name: cond_logic_pipe

Overview:
- Parametrised successor to the single-cycle ARM conditional logic, for the pipelined core.
- Evaluates all 16 ARM condition codes against banked NZCV flag registers and updates the flags selectively per FlagW.
- Gates PCS/RegW/MemW by the condition result, then delivers them through stall/flush-aware pipeline registers to the M and W stages.
- Sits between the decoder/ALU (E stage) and the hazard unit / writeback path.

Parameters:
- CTX_N, 2, number of banked NZCV flag sets (user/exception contexts); valid range 1..8.
- WB_LAT, 2, cycles from E-stage input to RegWrite output; valid range 1..4. PCSrc/MemWrite latency is fixed at 1.
- CW, (CTX_N>1 ? $clog2(CTX_N) : 1), width of the context select (derived; do not override).

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold all pipeline registers and flags
- flush  in  1  insert bubble: the E-stage instruction is killed
- ctx_sel  in  CW  flag bank used for evaluation and update
- Cond  in  4  instruction condition field
- ALUFlags  in  4  {N,Z,C,V} from ALU
- FlagW  in  2  [1]: write N,Z; [0]: write C,V
- PCS  in  1  instruction writes PC
- RegW  in  1  instruction writes register file
- MemW  in  1  instruction writes memory
- NoWrite  in  1  suppress register write (CMP/TST class)
- flags_load  in  1  direct write of bank ctx_sel (MSR)
- flags_in  in  4  value for flags_load
- CondEx  out  1  combinational condition-pass for the current E instruction
- Flags  out  4  current contents of bank ctx_sel
- PCSrc  out  1  registered, M stage
- MemWrite  out  1  registered, M stage
- RegWrite  out  1  registered, WB_LAT cycles after E

Behaviour:
- Reset: every flag bank = 4'b0000; all pipeline registers = 0, so PCSrc = MemWrite = RegWrite = 0. Reset overrides stall, flush and flags_load.
- Condition decode, using the selected bank {N,Z,C,V}:
  - 0 EQ: Z; 1 NE: !Z; 2 CS: C; 3 CC: !C
  - 4 MI: N; 5 PL: !N; 6 VS: V; 7 VC: !V
  - 8 HI: C&!Z; 9 LS: !C|Z; 10 GE: N==V; 11 LT: N!=V
  - 12 GT: !Z&(N==V); 13 LE: Z|(N!=V); 14 AL: 1; 15: 0 (see optional feature)
- CondEx uses the registered flags only, with no bypass. The flags written by instruction i are visible to instruction i+1 on the next cycle.
- Gated signals (E stage): pcs_g = PCS&CondEx; mem_g = MemW&CondEx; reg_g = RegW&CondEx&!NoWrite.
- Flag update on the rising edge, only when !stall & !flush & CondEx:
  - FlagW[1]: bank[ctx_sel].NZ <= ALUFlags[3:2]
  - FlagW[0]: bank[ctx_sel].CV <= ALUFlags[1:0]
  - Other banks are never touched.
- flags_load:
  - When flags_load & !stall, bank[ctx_sel] <= flags_in.
  - It takes priority over a simultaneous ALU update to the same bank.
  - It ignores Cond and flush.
- Pipeline:
  - Stage 1 register holds {pcs_g, mem_g, reg_g}; PCSrc and MemWrite are taken from stage 1.
  - RegWrite is the reg bit after WB_LAT registers in total.
- stall=1: all stages and flag banks hold their values; outputs stay constant.
- flush=1 with stall=0: stage 1 loads 0s; later stages advance normally.
- stall and flush together: stall wins (hold).
- A ctx_sel change takes effect combinationally on CondEx/Flags in the same cycle. In-flight pipeline bits are unaffected.
- Out-of-range ctx_sel (>= CTX_N): CondEx is forced 0, Flags = 0, and no flag write occurs.

Optional Feature:
- Macro: COND_UNDEF_TRAP_EN.
- Defined:
  - Adds output undef_trap (1 bit), registered into stage 1 and aligned with PCSrc.
  - undef_trap is set for Cond==4'b1111 when the instruction is not flushed.
  - A flush clears it; a stall holds it.
- Undefined: Cond==1111 silently never executes and no port exists.

Decomposition:
- Package cond_pkg:
  - enum cond_e (EQ..AL, NV = 4'hF)
  - typedef flags_t = struct packed {N,Z,C,V}
  - FLAGW_NZ and FLAGW_CV bit indices
- Sub-module cond_check: purely combinational (cond_e, flags_t) -> pass. Used once here and reusable by the branch predictor.
- Flag banks and the delay line stay in the top module.

Test Plan:
- Reset with all flags 0 → Flags=0, outputs 0.
  - Cond=EQ, RegW=1 → CondEx=0, RegWrite=0 after 2 cycles.
  - Cond=AL → RegWrite=1 after exactly 2 cycles.
- Cond=AL, FlagW=2'b10, ALUFlags=4'b0100 → Flags=0100 next cycle (C,V kept). Next instr Cond=EQ, MemW=1 → MemWrite=1 one cycle later.
- Sweep all 16 Cond × all 16 flag values via flags_load → CondEx matches the decode table. Cond=GT with flags 1001 → 1; with 1101 → 0.
- Conditional flag update is suppressed when the condition fails:
  - Cond=NE with Z=1, FlagW=3, ALUFlags=4'b0011 → Flags unchanged at 0100.
  - Also with NoWrite=1, RegW=1, Cond=AL → RegWrite=0.
- Pipeline control:
  - PCS=1, Cond=AL with flush=1 → PCSrc=0 and no flag update.
  - The same with stall=1 for 3 cycles → outputs hold; with flush+stall together → hold.
- CTX_N=2:
  - flags_load with ctx_sel=1, flags_in=1000 → bank0 still 0000.
  - Switch ctx_sel=1 → Cond=MI passes same cycle; ctx_sel back to 0 → fails.
- With COND_UNDEF_TRAP_EN: Cond=4'hF → undef_trap=1 one cycle later; flushed → 0.
